// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat round sequencer: FSM states, card ranks and
// the rank-to-point mapping used by the dealer third-card rule.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_DP1, S_DD1, S_DP2, S_DD2, S_EVAL,
    S_DP3, S_BEVAL, S_DD3, S_RESULT, S_DONE
  } state_e;

  localparam logic [3:0] RANK_EMPTY = 4'd0;
  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_TWO   = 4'd2;
  localparam logic [3:0] RANK_THREE = 4'd3;
  localparam logic [3:0] RANK_FOUR  = 4'd4;
  localparam logic [3:0] RANK_FIVE  = 4'd5;
  localparam logic [3:0] RANK_SIX   = 4'd6;
  localparam logic [3:0] RANK_SEVEN = 4'd7;
  localparam logic [3:0] RANK_EIGHT = 4'd8;
  localparam logic [3:0] RANK_NINE  = 4'd9;
  localparam logic [3:0] RANK_TEN   = 4'd10;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING  = 4'd13;

  // Tens and face cards count zero; an empty slot also counts zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= RANK_ACE && rank <= RANK_NINE) ? rank : 4'd0;
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Dealer third-card table: whether the dealer draws given its two-card score
// and the point value of the player's third card.
module banker_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Moore FSM sequencing one baccarat round: strobes card slots in dealing
// order, applies third-card rules to datapath scores, latches win lights.
module deal_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       clear_hands,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  state_e state_q, state_d;
  logic   pwin_q, dwin_q;
  logic   banker_draw;

  banker_rule u_banker_rule (
    .dscore (dscore),
    .v      (card_value(pcard3)),
    .draw   (banker_draw)
  );

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clear_hands = 1'b0;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR: begin
        clear_hands = 1'b1;
        state_d     = S_DP1;
      end
      S_DP1: begin load_pcard1 = 1'b1; state_d = S_DD1; end
      S_DD1: begin load_dcard1 = 1'b1; state_d = S_DP2; end
      S_DP2: begin load_pcard2 = 1'b1; state_d = S_DD2; end
      S_DD2: begin load_dcard2 = 1'b1; state_d = S_EVAL; end
      S_EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = S_RESULT;
        else if (pscore <= 4'd5)              state_d = S_DP3;
        else if (dscore <= 4'd5)              state_d = S_DD3;
        else                                  state_d = S_RESULT;
      end
      S_DP3:   begin load_pcard3 = 1'b1; state_d = S_BEVAL; end
      S_BEVAL: state_d = banker_draw ? S_DD3 : S_RESULT;
      S_DD3:   begin load_dcard3 = 1'b1; state_d = S_RESULT; end
      S_RESULT: state_d = S_DONE;
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lights drop as a new round enters CLR and are set only when leaving RESULT.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      pwin_q <= 1'b0;
      dwin_q <= 1'b0;
    end else if (state_d == S_CLR) begin
      pwin_q <= 1'b0;
      dwin_q <= 1'b0;
    end else if (state_q == S_RESULT) begin
      pwin_q <= (pscore >= dscore);
      dwin_q <= (dscore >= pscore);
    end
  end

  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: a per-round expected output schedule is
// built from the game rules and compared against the DUT every cycle.
module tb_deal_sequencer;

  logic       slow_clock = 1'b0;
  logic       reset, start;
  logic [3:0] pscore, dscore, pcard3;
  logic       clear_hands, load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;

  deal_sequencer dut (
    .slow_clock(slow_clock), .reset(reset), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .clear_hands(clear_hands),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .done(done)
  );

  always #5 slow_clock = ~slow_clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] steady = '0;
  logic       chk_en = 1'b0;
  logic       mute = 1'b0;
  int         cyc = 0;

  // {clear, lp1, ld1, lp2, ld2, lp3, ld3, done, pwin, dwin}
  function automatic logic [9:0] act_vec();
    return {clear_hands, load_pcard1, load_dcard1, load_pcard2, load_dcard2,
            load_pcard3, load_dcard3, done, player_win_light, dealer_win_light};
  endfunction

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic int cval(input int rank);
    return (rank >= 1 && rank <= 9) ? rank : 0;
  endfunction

  // Dealer draw set per two-card score, as a bitmask over third-card value.
  function automatic bit model_draw(input int d, input int v);
    bit [9:0] mask;
    case (d)
      0, 1, 2: mask = 10'h3FF;
      3:       mask = 10'h2FF;
      4:       mask = 10'h0FC;
      5:       mask = 10'h0F0;
      6:       mask = 10'h0C0;
      default: mask = 10'h000;
    endcase
    return mask[v];
  endfunction

  function automatic int round_len(input int p, input int d, input int c3);
    if (p >= 8 || d >= 8) return 7;
    if (p <= 5) return model_draw(d, cval(c3)) ? 10 : 9;
    return (d <= 5) ? 8 : 7;
  endfunction

  task automatic push_round(input int p, input int d, input int c3, input int pf, input int df);
    bit natural, pdraw, ddraw;
    natural = (p >= 8 || d >= 8);
    pdraw   = !natural && p <= 5;
    ddraw   = !natural && (pdraw ? model_draw(d, cval(c3)) : d <= 5);
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h080);
    exp_q.push_back(10'h040);
    exp_q.push_back(10'h020);
    exp_q.push_back(10'h000);
    if (pdraw) begin
      exp_q.push_back(10'h010);
      exp_q.push_back(10'h000);
    end
    if (ddraw) exp_q.push_back(10'h008);
    exp_q.push_back(10'h000);
    exp_q.push_back({7'b0, 1'b1, pf >= df, df >= pf});
  endtask

  always @(posedge slow_clock) begin
    #1;
    cyc++;
    if (chk_en && !mute) begin
      if (exp_q.size() > 0) steady = exp_q.pop_front();
      check("cycle", act_vec(), steady);
    end
  end

  task automatic run(input int p, input int d, input int c3, input int pf, input int df);
    int len;
    len = round_len(p, d, c3);
    @(negedge slow_clock);
    pscore = 4'(p); dscore = 4'(d); pcard3 = 4'(c3);
    push_round(p, d, c3, pf, df);
    start = 1'b1;
    @(posedge slow_clock);
    @(negedge slow_clock);
    start = 1'b0;
    repeat (len - 1) @(posedge slow_clock);
    @(negedge slow_clock);
    pscore = 4'(pf); dscore = 4'(df);
    repeat (4) @(posedge slow_clock);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    pscore = '0; dscore = '0; pcard3 = '0;
    #3;
    check("reset_state", act_vec(), 10'h000);

    check_int("pin_draw_3_8", int'(model_draw(3, 8)), 0);
    check_int("pin_draw_4_1", int'(model_draw(4, 1)), 0);
    check_int("pin_draw_6_7", int'(model_draw(6, 7)), 1);
    check_int("pin_len_natural", round_len(9, 3, 0), 7);
    check_int("pin_len_both", round_len(4, 3, 7), 10);
    check_int("pin_len_pdraw", round_len(2, 3, 8), 9);
    check_int("pin_len_ddraw", round_len(7, 5, 0), 8);
    check_int("pin_cval_queen", cval(12), 0);

    @(negedge slow_clock);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge slow_clock);

    run(9, 3, 0, 9, 3);   // natural
    run(4, 3, 7, 6, 6);   // both draw, tie
    run(2, 3, 8, 2, 3);   // banker stands on an 8
    run(2, 3, 12, 2, 3);  // queen counts zero, banker draws
    run(7, 5, 0, 7, 5);   // player stands, dealer draws
    run(7, 6, 0, 7, 6);   // both stand
    run(3, 4, 1, 3, 4);   // ace: dealer on 4 stands
    run(4, 6, 6, 4, 6);   // dealer on 6 draws on a six

    // Reset asserted asynchronously in the middle of DD1.
    @(negedge slow_clock);
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd7;
    push_round(4, 3, 7, 4, 3);
    start = 1'b1;
    @(posedge slow_clock);
    @(negedge slow_clock);
    start = 1'b0;
    repeat (2) @(posedge slow_clock);
    #3;
    mute = 1'b1;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("async_reset", act_vec(), 10'h000);
    repeat (2) @(negedge slow_clock);
    reset = 1'b0;
    steady = '0;
    mute = 1'b0;
    repeat (4) @(posedge slow_clock);

    // Start held high: ignored mid-round, restarts from DONE after one cycle.
    @(negedge slow_clock);
    pscore = 4'd8; dscore = 4'd8; pcard3 = 4'd0;
    push_round(8, 8, 0, 8, 8);
    push_round(5, 7, 0, 5, 7);
    start = 1'b1;
    repeat (round_len(8, 8, 0) + 1) @(posedge slow_clock);
    @(negedge slow_clock);
    pscore = 4'd5; dscore = 4'd7;
    @(posedge slow_clock);
    @(negedge slow_clock);
    start = 1'b0;
    repeat (round_len(5, 7, 0) + 3) @(posedge slow_clock);

    run(7, 6, 0, 7, 6);
    check_int("queue_drained", exp_q.size(), 0);

    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
